// File: rtl/cvxif_offload_master.sv
// cvxif_offload_master: core-side CV-X-IF initiator.
//  Offloads one instruction at a time over the shared issue/register channel, hands out
//  IDs for accepted instructions, forwards in-order commit/kill decisions, buffers
//  coprocessor results and writes them back to the core under backpressure.
// Ports:
//  clk_i, rst_ni                  clock, synchronous active-low reset
//  off_*                          core offload request and issue decision response
//  cmt_valid_i, cmt_kill_i        core commit/kill for the oldest uncommitted instruction
//  x_issue_*, x_register_rs_o     coprocessor issue/register channel
//  x_commit_*                     coprocessor commit channel
//  x_result_*                     coprocessor result channel
//  wb_*                           writeback to the core (head of result buffer)
//  err_o                          sticky protocol error
// Build option: CVXIF_RESULT_BYPASS_EN forwards a result straight to wb_* when the
//  result buffer is empty and the core is ready (0-cycle latency).
module cvxif_offload_master #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NrRgprPorts   = 2,
  parameter int unsigned IdWidth       = 3,
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned ResFifoDepth  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          off_valid_i,
  output logic                          off_ready_o,
  input  logic [31:0]                   off_instr_i,
  input  logic [NrRgprPorts*XLEN-1:0]   off_rs_i,
  output logic                          off_resp_valid_o,
  output logic                          off_resp_accept_o,
  output logic [IdWidth-1:0]            off_resp_id_o,
  input  logic                          cmt_valid_i,
  input  logic                          cmt_kill_i,
  output logic                          x_issue_valid_o,
  input  logic                          x_issue_ready_i,
  output logic [31:0]                   x_issue_instr_o,
  output logic [IdWidth-1:0]            x_issue_id_o,
  output logic [NrRgprPorts*XLEN-1:0]   x_register_rs_o,
  input  logic                          x_issue_accept_i,
  output logic                          x_commit_valid_o,
  output logic [IdWidth-1:0]            x_commit_id_o,
  output logic                          x_commit_kill_o,
  input  logic                          x_result_valid_i,
  output logic                          x_result_ready_o,
  input  logic [IdWidth-1:0]            x_result_id_i,
  input  logic [XLEN-1:0]               x_result_data_i,
  input  logic [4:0]                    x_result_rd_i,
  input  logic                          x_result_we_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [IdWidth-1:0]            wb_id_o,
  output logic [XLEN-1:0]               wb_data_o,
  output logic [4:0]                    wb_rd_o,
  output logic                          wb_we_o,
  output logic                          err_o
);

  localparam int unsigned RsW    = NrRgprPorts * XLEN;
  localparam int unsigned NumIds = 2 ** IdWidth;
  localparam int unsigned OutW   = $clog2(NrOutstanding + 1);
  localparam int unsigned CqAw   = (NrOutstanding > 1) ? $clog2(NrOutstanding) : 1;
  localparam int unsigned RfAw   = (ResFifoDepth > 1) ? $clog2(ResFifoDepth) : 1;
  localparam int unsigned RfCw   = $clog2(ResFifoDepth + 1);

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [XLEN-1:0]    data;
    logic [4:0]         rd;
    logic               we;
  } res_t;

  typedef enum logic [0:0] {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         instr_q;
  logic [RsW-1:0]      rs_q;
  logic [IdWidth-1:0]  next_id_q;
  logic [OutW-1:0]     out_cnt_q, out_cnt_d;
  logic [NumIds-1:0]   pending_q, pending_d;
  logic                resp_valid_q, resp_accept_q;
  logic [IdWidth-1:0]  resp_id_q;
  logic                commit_valid_q, commit_kill_q;
  logic [IdWidth-1:0]  commit_id_q;
  logic                err_q;

  // In-order commit queue of accepted IDs
  logic [IdWidth-1:0]  cq_mem [NrOutstanding];
  logic [CqAw-1:0]     cq_wr_q, cq_rd_q;
  logic [OutW-1:0]     cq_cnt_q;

  // Result buffer
  res_t                rf_mem [ResFifoDepth];
  logic [RfAw-1:0]     rf_wr_q, rf_rd_q;
  logic [RfCw-1:0]     rf_cnt_q;

  logic issue_hs, accept, cq_full, cq_empty, cmt_ok, cmt_err;
  logic res_hs, res_ok, res_err, kill_dec, rf_full, rf_empty, rf_push, rf_pop;
  logic [IdWidth-1:0] cmt_id;
  res_t res_in, wb_sel;

  function automatic logic [CqAw-1:0] cq_inc(input logic [CqAw-1:0] p);
    return (p == CqAw'(NrOutstanding - 1)) ? '0 : p + CqAw'(1);
  endfunction

  function automatic logic [RfAw-1:0] rf_inc(input logic [RfAw-1:0] p);
    return (p == RfAw'(ResFifoDepth - 1)) ? '0 : p + RfAw'(1);
  endfunction

  // Issue FSM: next state and FSM-derived outputs
  always_comb begin
    state_d         = state_q;
    off_ready_o     = 1'b0;
    x_issue_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        off_ready_o = (out_cnt_q < OutW'(NrOutstanding)) && !cq_full;
        if (off_valid_i && off_ready_o) state_d = ISSUE;
      end
      ISSUE: begin
        x_issue_valid_o = 1'b1;
        if (x_issue_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake decode, bookkeeping next values and writeback selection
  always_comb begin
    issue_hs = (state_q == ISSUE) && x_issue_ready_i;
    accept   = issue_hs && x_issue_accept_i;
    cq_full  = (cq_cnt_q == OutW'(NrOutstanding));
    cq_empty = (cq_cnt_q == '0);
    cmt_ok   = cmt_valid_i && !cq_empty;
    cmt_err  = cmt_valid_i && cq_empty;
    cmt_id   = cq_mem[cq_rd_q];
    rf_full  = (rf_cnt_q == RfCw'(ResFifoDepth));
    rf_empty = (rf_cnt_q == '0);
    x_result_ready_o = !rf_full;
    res_hs   = x_result_valid_i && x_result_ready_o;
    res_ok   = res_hs && pending_q[x_result_id_i];
    res_err  = res_hs && !pending_q[x_result_id_i];
    // A kill racing a result for the same ID must not retire it twice
    kill_dec = cmt_ok && cmt_kill_i && pending_q[cmt_id] &&
               !(res_ok && (x_result_id_i == cmt_id));
    out_cnt_d = out_cnt_q + OutW'(accept) - OutW'(res_ok) - OutW'(kill_dec);

    pending_d = pending_q;
    if (res_ok) pending_d[x_result_id_i] = 1'b0;
    if (cmt_ok && cmt_kill_i) pending_d[cmt_id] = 1'b0;
    if (accept) pending_d[next_id_q] = 1'b1;

    res_in = '{id: x_result_id_i, data: x_result_data_i, rd: x_result_rd_i, we: x_result_we_i};
    wb_sel = rf_mem[rf_rd_q];
`ifdef CVXIF_RESULT_BYPASS_EN
    wb_valid_o = !rf_empty || res_ok;
    if (rf_empty) wb_sel = res_in;
    rf_push = res_ok && !(rf_empty && wb_ready_i);
`else
    wb_valid_o = !rf_empty;
    rf_push    = res_ok;
`endif
    rf_pop = !rf_empty && wb_ready_i;
  end

  assign wb_id_o           = wb_sel.id;
  assign wb_data_o         = wb_sel.data;
  assign wb_rd_o           = wb_sel.rd;
  assign wb_we_o           = wb_sel.we;
  assign x_issue_instr_o   = instr_q;
  assign x_register_rs_o   = rs_q;
  assign x_issue_id_o      = next_id_q;
  assign off_resp_valid_o  = resp_valid_q;
  assign off_resp_accept_o = resp_accept_q;
  assign off_resp_id_o     = resp_id_q;
  assign x_commit_valid_o  = commit_valid_q;
  assign x_commit_id_o     = commit_id_q;
  assign x_commit_kill_o   = commit_kill_q;
  assign err_o             = err_q;

  // Control state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      rs_q           <= '0;
      next_id_q      <= '0;
      out_cnt_q      <= '0;
      pending_q      <= '0;
      resp_valid_q   <= 1'b0;
      resp_accept_q  <= 1'b0;
      resp_id_q      <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_kill_q  <= 1'b0;
      err_q          <= 1'b0;
      cq_wr_q        <= '0;
      cq_rd_q        <= '0;
      cq_cnt_q       <= '0;
      rf_wr_q        <= '0;
      rf_rd_q        <= '0;
      rf_cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && off_valid_i && off_ready_o) begin
        instr_q <= off_instr_i;
        rs_q    <= off_rs_i;
      end
      if (accept) next_id_q <= next_id_q + IdWidth'(1);
      out_cnt_q      <= out_cnt_d;
      pending_q      <= pending_d;
      resp_valid_q   <= issue_hs;
      resp_accept_q  <= accept;
      resp_id_q      <= next_id_q;
      commit_valid_q <= cmt_ok;
      commit_id_q    <= cmt_id;
      commit_kill_q  <= cmt_kill_i;
      if (res_err || cmt_err) err_q <= 1'b1;
      if (accept) cq_wr_q <= cq_inc(cq_wr_q);
      if (cmt_ok) cq_rd_q <= cq_inc(cq_rd_q);
      cq_cnt_q <= cq_cnt_q + OutW'(accept) - OutW'(cmt_ok);
      if (rf_push) rf_wr_q <= rf_inc(rf_wr_q);
      if (rf_pop)  rf_rd_q <= rf_inc(rf_rd_q);
      rf_cnt_q <= rf_cnt_q + RfCw'(rf_push) - RfCw'(rf_pop);
    end
  end

  // Queue storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk_i) begin
    if (accept)  cq_mem[cq_wr_q] <= next_id_q;
    if (rf_push) rf_mem[rf_wr_q] <= res_in;
  end

endmodule
